// File: rtl/decode_issue_queue.sv
// ---------------------------------------------------------------------------
// decode_issue_queue
//   Circular FIFO of decoded instructions sitting between decode and
//   issue-dispatch. Decode pushes up to two entries per cycle in program
//   order; dispatch sees the two oldest entries and retires 0..2 per cycle.
//   Decode keeps running while issue is stalled; a flush empties the queue.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (priority over everything)
//   flush       synchronous clear of all entries (branch/exception redirect)
//   i_set1/2    older / younger decoded instruction from decode
//   i_push      push valid, bit1 = i_set1, bit0 = i_set2
//   o_ready     queue has room for two entries (count <= DEPTH-2)
//   o_set1/2    entry at head / head+1, all-zero when not valid
//   o_is_valid  bit1 = o_set1 valid, bit0 = o_set2 valid
//   i_usingNUM  entries consumed by dispatch this cycle (3 is illegal)
//   o_count     current occupancy
//   o_stall_cnt (only with DECODE_ISSUE_QUEUE_STAT_EN) saturating count of
//               cycles with a non-empty queue and nothing consumed
//
// Optional macro: DECODE_ISSUE_QUEUE_STAT_EN
// ---------------------------------------------------------------------------
package decode_issue_queue_pkg;
    typedef struct packed {
        logic        o_valid;
        logic [31:0] PC;
        logic [31:0] inst;
    } PC_set;
endpackage

module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  PC_set            i_set1,
    input  PC_set            i_set2,
    input  logic [1:0]       i_push,
    output logic             o_ready,
    output PC_set            o_set1,
    output PC_set            o_set2,
    output logic [1:0]       o_is_valid,
    input  logic [1:0]       i_usingNUM,
    output logic [PTR_W:0]   o_count
`ifdef DECODE_ISSUE_QUEUE_STAT_EN
    ,
    output logic [31:0]      o_stall_cnt
`endif
);
    localparam int NUM_LANES = 2;

    PC_set            mem [DEPTH];
    logic [PTR_W-1:0] head, tail, tail_p1;
    logic [PTR_W:0]   count, count_nxt;

    logic             push_ok;
    logic [1:0]       push_n, pop_req, pop_n;

    // Ready looks at the current count only; a same-cycle pop is not credited.
    assign o_ready = (count <= (PTR_W+1)'(DEPTH - 2));
    assign push_ok = o_ready && (|i_push);
    assign push_n  = push_ok ? ({1'b0, i_push[1]} + {1'b0, i_push[0]}) : 2'd0;

    // Illegal usingNUM=3 retires nothing; requests beyond occupancy are clamped.
    assign pop_req = (i_usingNUM == 2'd3) ? 2'd0 : i_usingNUM;
    assign pop_n   = ((PTR_W+1)'(pop_req) > count) ? count[1:0] : pop_req;

    assign count_nxt = count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    assign tail_p1   = tail + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count_nxt;
        end
    end

    // Storage has no reset; stale contents are masked by the valid gating.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            case (i_push)
                2'b11: begin
                    mem[tail]    <= i_set1;
                    mem[tail_p1] <= i_set2;
                end
                2'b10:   mem[tail] <= i_set1;
                2'b01:   mem[tail] <= i_set2;
                default: ;
            endcase
        end
    end

    // Read lanes: lane l presents entry[head+l], valid when count > l.
    logic [NUM_LANES-1:0] lane_vld;
    PC_set                lane_set [NUM_LANES];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [PTR_W-1:0] rd_ptr;
        assign rd_ptr      = head + PTR_W'(l);
        assign lane_vld[l] = (count > (PTR_W+1)'(l));
        always_comb begin
            lane_set[l] = '0;
            if (lane_vld[l]) begin
                lane_set[l]         = mem[rd_ptr];
                lane_set[l].o_valid = 1'b1;
            end
        end
    end

    assign o_set1     = lane_set[0];
    assign o_set2     = lane_set[1];
    assign o_is_valid = {lane_vld[0], lane_vld[1]};
    assign o_count    = count;

`ifdef DECODE_ISSUE_QUEUE_STAT_EN
    // Counts cycles where dispatch holds off a non-empty queue; survives flush.
    always_ff @(posedge clk) begin
        if (rst)
            o_stall_cnt <= '0;
        else if ((count != '0) && (i_usingNUM == 2'd0) && (o_stall_cnt != 32'hFFFF_FFFF))
            o_stall_cnt <= o_stall_cnt + 32'd1;
    end
`endif

    // Protocol checks on the decode/dispatch handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (i_usingNUM != 2'd3);
            assert (flush || !(|i_push) || o_ready);
        end
    end
endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Circular FIFO of decoded instructions between the decoder and the issue-dispatch stage.
- Accepts up to two PC_set entries per cycle from decode, in program order.
- Presents the two oldest entries to dispatch and retires 0, 1 or 2 of them per cycle according to dispatch's usingNUM.
- Decouples decode from issue stalls (load-use interlock, pairing restrictions) and is cleared on pipeline flush.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- PTR_W, $clog2(DEPTH), head/tail pointer width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all entries; from branch/exception redirect.
- i_set1  in  PC_set  older decoded instruction from decode.
- i_set2  in  PC_set  younger decoded instruction from decode.
- i_push  in  2  push valid; bit1 = i_set1, bit0 = i_set2.
- o_ready  out  1  queue can accept two entries this cycle (free >= 2).
- o_set1  out  PC_set  oldest entry, at head.
- o_set2  out  PC_set  second-oldest entry, at head+1.
- o_is_valid  out  2  bit1 = o_set1 valid, bit0 = o_set2 valid.
- i_usingNUM  in  2  number of entries consumed by dispatch this cycle.
- o_count  out  PTR_W+1  current occupancy.

Behaviour:
- State: entry array DEPTH x PC_set, head, tail (PTR_W, wrap modulo DEPTH), count (PTR_W+1).
- Reset (rst=1 at edge): head=tail=count=0.
  - Outputs: o_is_valid=2'b00, o_count=0, o_ready=1, o_set1/o_set2 all-zero.
  - rst has priority over flush, push and pop.
- Flush (flush=1 at edge, rst=0): same state as reset. Push and pop in the same cycle are ignored.
- Outputs are combinational from registered state; there is no internal combinational path from i_push or i_usingNUM to any output.
  - o_is_valid = {count>=1, count>=2}.
  - o_set1 = entry[head]; o_set2 = entry[head+1 mod DEPTH].
  - Each o_setN is forced to all-zero when its valid bit is 0.
  - o_setN.o_valid field = corresponding o_is_valid bit.
- o_ready = (count <= DEPTH-2). It is computed from current count only and does not credit same-cycle pops. Decode must push only when o_ready=1.
- Push, effective only when o_ready=1:
  - i_push=11: entry[tail]=i_set1, entry[tail+1]=i_set2, tail+=2.
  - i_push=10: entry[tail]=i_set1, tail+=1.
  - i_push=01: entry[tail]=i_set2, tail+=1.
  - Pushed data is visible on outputs no earlier than the next cycle; there is no bypass when empty.
- Pop:
  - pop_n = i_usingNUM clamped to min(i_usingNUM, count).
  - i_usingNUM=3 is illegal and treated as 0; simulation assertion fires.
  - head += pop_n.
- Simultaneous push and pop: count_next = count + push_n - pop_n. Both operate in the same edge.
- Push while o_ready=0 is dropped and the state is unchanged; simulation assertion fires.
- Wrap-around: pointer arithmetic is modulo DEPTH. o_set2 reads entry[0] when head=DEPTH-1.
- Full (count=DEPTH): o_ready=0. Pops proceed normally.
- Empty (count=0): o_is_valid=00. Any i_usingNUM is ignored.

Optional Feature:
- Macro: DECODE_ISSUE_QUEUE_STAT_EN.
- When defined:
  - Adds output o_stall_cnt, 32 bits, initialised to 0 by rst (not by flush).
  - Increments by 1 each cycle in which count>=1 and i_usingNUM==0.
  - Saturates at 32'hFFFF_FFFF.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then i_push=00.
  - Required: o_is_valid=00, o_count=0, o_ready=1, o_set1/o_set2 all-zero.
- Dual push, dual pop:
  - Push PC 0x1c000000/0x1c000004 with i_push=11.
  - Next cycle: o_is_valid=11, o_set1.PC=0x1c000000, o_set2.PC=0x1c000004.
  - Drive i_usingNUM=2. Required next cycle: o_count=0, o_is_valid=00.
- Partial pop with concurrent push:
  - With 2 entries held, i_usingNUM=1 and i_push=11.
  - Required next cycle: o_count=3, o_set1 = former o_set2, o_set2 = first of new pair.
- Fill and wrap:
  - Push pairs until o_count=8. Required: o_ready=0.
  - Pop 1/cycle and push pairs whenever o_ready=1 for 20 cycles.
  - Required: FIFO order preserved across head=7 -> 0, including o_set2 from entry[0].
- Flush mid-stream:
  - With 5 entries held, assert flush with i_push=11 and i_usingNUM=2.
  - Required next cycle: o_count=0, o_is_valid=00; the pushed pair is discarded.
- Clamp and stat:
  - With 1 entry held, i_usingNUM=2. Required next cycle: o_count=0, no underflow.
  - With DECODE_ISSUE_QUEUE_STAT_EN defined: 3 cycles with count>=1 and i_usingNUM=0 -> o_stall_cnt=3.
